// File: rtl/nes_mem_arbiter_if.sv
// nes_mem_arbiter_if: external memory port between the arbiter (master) and the memory controller (slave)
interface nes_mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter: loader FIFO plus PPU/CPU arbitration onto one external memory port.
// Define NES_ARB_STATS_EN to add per-requester completion counters and a forced-grant counter.
module nes_mem_arbiter #(
  parameter int LFIFO_DEPTH  = 4,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_write,
  input  logic [21:0]       ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_done,
  output logic              ld_overflow,
  input  logic              ppu_req,
  input  logic [21:0]       ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [21:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  nes_mem_arbiter_if.master mem
`ifdef NES_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_ppu,
  output logic [15:0]       stat_cpu,
  output logic [7:0]        stat_starve
`endif
);
  localparam int AW = $clog2(LFIFO_DEPTH);
  localparam int WW = $clog2(CPU_MAX_WAIT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_LD, OWN_PPU, OWN_CPU} owner_t;
  state_t        state;
  owner_t        owner;
  logic [21:0]   fifo_addr [LFIFO_DEPTH];
  logic [7:0]    fifo_data [LFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [WW-1:0] wait_cnt;
  logic          fifo_empty, fifo_full, push, forced, grant_ld, grant_ppu, grant_cpu;
  always_comb begin
    fifo_empty = count == '0;
    fifo_full  = count == (AW+1)'(LFIFO_DEPTH);
    push       = ld_write && !fifo_full;
    forced     = cpu_req && wait_cnt == WW'(CPU_MAX_WAIT);
    grant_ld   = state == IDLE && !fifo_empty;
    grant_ppu  = state == IDLE && fifo_empty && ld_done && ppu_req && !forced;
    grant_cpu  = state == IDLE && fifo_empty && ld_done && cpu_req && (forced || !ppu_req);
  end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr[wr_ptr] <= ld_addr;
      fifo_data[wr_ptr] <= ld_data;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= OWN_LD;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wait_cnt      <= '0;
      ld_overflow   <= 1'b0;
      ppu_ack       <= 1'b0;
      cpu_ack       <= 1'b0;
      ppu_rdata     <= '0;
      cpu_rdata     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      ppu_ack <= 1'b0;
      cpu_ack <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (grant_ld) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(grant_ld);
      if (ld_write && fifo_full) ld_overflow <= 1'b1;
      if (!cpu_req || grant_cpu) wait_cnt <= '0;
      else if ((grant_ld || grant_ppu) && wait_cnt != WW'(CPU_MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
      if (grant_ld) begin
        state         <= BUSY;
        owner         <= OWN_LD;
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= 1'b1;
        mem.mem_addr  <= fifo_addr[rd_ptr];
        mem.mem_wdata <= fifo_data[rd_ptr];
      end else if (grant_ppu) begin
        state         <= BUSY;
        owner         <= OWN_PPU;
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= 1'b0;
        mem.mem_addr  <= ppu_addr;
        mem.mem_wdata <= '0;
      end else if (grant_cpu) begin
        state         <= BUSY;
        owner         <= OWN_CPU;
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= cpu_we;
        mem.mem_addr  <= cpu_addr;
        mem.mem_wdata <= cpu_wdata;
      end else if (state == BUSY && mem.mem_ack) begin
        state       <= IDLE;
        mem.mem_req <= 1'b0;
        ppu_ack     <= owner == OWN_PPU;
        cpu_ack     <= owner == OWN_CPU;
        if (owner == OWN_PPU) ppu_rdata <= mem.mem_rdata;
        // a CPU write leaves cpu_rdata holding its last read value
        if (owner == OWN_CPU && !mem.mem_we) cpu_rdata <= mem.mem_rdata;
      end
    end
`ifdef NES_ARB_STATS_EN
  logic done;
  assign done = state == BUSY && mem.mem_ack;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_ld     <= '0;
      stat_ppu    <= '0;
      stat_cpu    <= '0;
      stat_starve <= '0;
    end else begin
      if (done && owner == OWN_LD && stat_ld != '1) stat_ld <= stat_ld + 16'd1;
      if (done && owner == OWN_PPU && stat_ppu != '1) stat_ppu <= stat_ppu + 16'd1;
      if (done && owner == OWN_CPU && stat_cpu != '1) stat_cpu <= stat_cpu + 16'd1;
      if (grant_cpu && forced && stat_starve != '1) stat_starve <= stat_starve + 8'd1;
    end
`endif
endmodule
